mem_write_buffer: RTL
=====================

MEM_WRITE_BUFFER -- requirements
Module: mem_write_buffer

Interface
REQ-001 Parameters: DEPTH, default 4, write-FIFO entries (power of 2, >=2); RD_LAT, default 1, cycles from mem_addr presented (mem_stall low) to valid mem_rdata.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 cpu_req  input  1  CPU request valid.
REQ-005 cpu_we  input  1  1 = word write, 0 = word read.
REQ-006 cpu_addr  input  32  byte address, word access.
REQ-007 cpu_wdata  input  32  write data.
REQ-008 cpu_ready  output  1  request accepted at an edge where cpu_req and cpu_ready are both high.
REQ-009 cpu_rdata  output  32  read data, registered.
REQ-010 cpu_rvalid  output  1  one-cycle pulse, cpu_rdata valid.
REQ-011 mem_addr  output  32  registered memory address.
REQ-012 mem_wr  output  1  registered memory write strobe.
REQ-013 mem_wdata  output  32  registered memory write data.
REQ-014 mem_rdata  input  32  memory read data.
REQ-015 mem_stall  input  1  high = memory takes no new operation this cycle.

Function
REQ-016 FSM states IDLE, RD_ADDR, RD_WAIT; cpu_ready = (state==IDLE) and not full, combinational.
REQ-017 Accepted write: push {cpu_addr, cpu_wdata} at the accepting edge; count +1.
REQ-018 Accepted read: compare cpu_addr (all 32 bits) with every valid entry, including the head.
REQ-019 Read hit: youngest matching entry's data loaded into cpu_rdata; cpu_rvalid high the next cycle; FSM stays IDLE; no memory access.
REQ-020 Read miss: latch address; next cycle RD_ADDR with mem_addr = latched address, mem_wr = 0.
REQ-021 RD_ADDR held while mem_stall high; after one cycle with mem_stall low go to RD_WAIT for RD_LAT cycles, then capture mem_rdata into cpu_rdata, pulse cpu_rvalid and return to IDLE in the same cycle.
REQ-022 Drain: at an edge in IDLE with FIFO non-empty, mem_stall low and no read miss accepted, pop head; the next cycle mem_wr = 1, mem_addr/mem_wdata = head; otherwise mem_wr = 0 the next cycle.
REQ-023 A read miss accepted at an edge takes priority over draining at that edge.
REQ-024 Simultaneous push and pop: count unchanged, pointers both advance.
REQ-025 Full (count==DEPTH): cpu_ready low and no request is accepted until a pop occurs.
REQ-026 Empty: no mem_wr pulses; a read always misses.
REQ-027 Pointers wrap modulo DEPTH; count width clog2(DEPTH)+1.
REQ-028 Entries drain strictly in push order, one per cycle at most; mem_wr never high for more than one cycle per entry.
REQ-029 A memory read is never issued while a matching write remains buffered (REQ-019 guarantees this).

Reset
REQ-030 At a reset edge: FIFO emptied (pending writes discarded), state IDLE, cpu_rdata = 0, cpu_rvalid = 0, mem_addr = 0, mem_wr = 0, mem_wdata = 0.
REQ-031 Reset overrides any simultaneous request, drain or outstanding read; no cpu_rvalid is produced for an aborted read.

Verification
REQ-032 Reset, write 0x10<-0xDEADBEEF accepted in cycle N -> mem_wr=1, mem_addr=0x10, mem_wdata=0xDEADBEEF in cycle N+2 only.
REQ-033 mem_stall=1, write 0x20<-0x1111 then 0x20<-0x2222, read 0x20 -> cpu_rvalid next cycle, cpu_rdata=0x2222, mem_wr stays 0.
REQ-034 mem_stall=1, write 4 distinct words -> cpu_ready=0 with count 4; release stall -> 4 mem_wr pulses in push order, cpu_ready=1 after first pop.
REQ-035 FIFO empty, RD_LAT=1, mem_rdata=0xCAFEF00D, read 0x40 accepted in cycle N -> mem_addr=0x40 in N+1, cpu_rvalid=1 with 0xCAFEF00D in N+3, cpu_ready low in N+1..N+2.
REQ-036 Reset asserted in RD_WAIT with 2 entries buffered -> next cycle state IDLE, count 0, no cpu_rvalid, no mem_wr afterwards.

Source files
------------

// File: rtl/mem_write_buffer.sv
// Posted-write buffer between a CPU port and a single-port memory.
// Writes are queued in a small FIFO and drained whenever memory is idle.
// Reads are forwarded from the youngest matching buffered write, or go to
// memory on a miss.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | accepting requests; draining FIFO head when memory is free
// RD_ADDR | read-miss address on mem_addr, held until mem_stall drops
// RD_WAIT | counting down memory read latency, then returning data
module mem_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ready,
  output logic [31:0] cpu_rdata,
  output logic        cpu_rvalid,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_stall
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {IDLE, RD_ADDR, RD_WAIT} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     rd_addr_q, rd_addr_d;
  logic [LW-1:0]   lat_cnt_q, lat_cnt_d;
  logic [31:0]     cpu_rdata_q, cpu_rdata_d;
  logic            cpu_rvalid_q, cpu_rvalid_d;
  logic [31:0]     mem_addr_q, mem_addr_d;
  logic            mem_wr_q, mem_wr_d;
  logic [31:0]     mem_wdata_q, mem_wdata_d;

  logic [31:0]     fifo_addr_q [DEPTH];
  logic [31:0]     fifo_data_q [DEPTH];

  logic            accept, push, rd_accept, rd_miss, pop;
  logic            hit;
  logic [31:0]     hit_data;
  logic [PW-1:0]   idx;

  assign cpu_ready  = (state_q == IDLE) && (count_q != CW'(DEPTH));
  assign accept     = cpu_req && cpu_ready;
  assign push       = accept && cpu_we;
  assign rd_accept  = accept && !cpu_we;
  assign rd_miss    = rd_accept && !hit;
  // A read miss owns the memory port at its accepting edge, so drain waits.
  assign pop        = (state_q == IDLE) && (count_q != '0) && !mem_stall && !rd_miss;

  assign cpu_rdata  = cpu_rdata_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wr     = mem_wr_q;
  assign mem_wdata  = mem_wdata_q;

  // Search valid entries oldest to youngest so the youngest match wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = rd_ptr_q;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      if ((CW'(i) < count_q) && (fifo_addr_q[idx] == cpu_addr)) begin
        hit      = 1'b1;
        hit_data = fifo_data_q[idx];
      end
    end
  end

  // Next-state, FIFO bookkeeping and registered output values.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    rd_addr_d    = rd_addr_q;
    lat_cnt_d    = lat_cnt_q;
    cpu_rdata_d  = cpu_rdata_q;
    cpu_rvalid_d = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wr_d     = 1'b0;
    mem_wdata_d  = mem_wdata_q;

    case (state_q)
      IDLE: begin
        if (rd_accept && hit) begin
          cpu_rdata_d  = hit_data;
          cpu_rvalid_d = 1'b1;
        end else if (rd_miss) begin
          rd_addr_d  = cpu_addr;
          mem_addr_d = cpu_addr;
          state_d    = RD_ADDR;
        end
        if (pop) begin
          mem_wr_d    = 1'b1;
          mem_addr_d  = fifo_addr_q[rd_ptr_q];
          mem_wdata_d = fifo_data_q[rd_ptr_q];
        end
      end
      RD_ADDR: begin
        mem_addr_d = rd_addr_q;
        if (!mem_stall) begin
          lat_cnt_d = LW'(RD_LAT - 1);
          state_d   = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (lat_cnt_q == '0) begin
          cpu_rdata_d  = mem_rdata;
          cpu_rvalid_d = 1'b1;
          state_d      = IDLE;
        end else begin
          lat_cnt_d = lat_cnt_q - LW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rd_addr_q    <= '0;
      lat_cnt_q    <= '0;
      cpu_rdata_q  <= '0;
      cpu_rvalid_q <= 1'b0;
      mem_addr_q   <= '0;
      mem_wr_q     <= 1'b0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      rd_addr_q    <= rd_addr_d;
      lat_cnt_q    <= lat_cnt_d;
      cpu_rdata_q  <= cpu_rdata_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      mem_addr_q   <= mem_addr_d;
      mem_wr_q     <= mem_wr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  // FIFO storage; contents are only meaningful under count_q, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= cpu_addr;
      fifo_data_q[wr_ptr_q] <= cpu_wdata;
    end
  end

endmodule
